// File: rtl/maxfinder_sched.sv
// Round-robin scheduler sharing one maxfinder datapath among N_REQ requesters.
// Latches the winner's operands, waits for done (with timeout) and returns a tagged result.
module maxfinder_sched #(
  parameter int N_REQ   = 4,
  parameter int W       = 5,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*5*W-1:0]   req_data,
  output logic                   rsp_valid,
  output logic [2:0]             rsp_id,
  output logic [W-1:0]           rsp_data,
  output logic                   rsp_err,
  output logic                   busy,
  output logic                   mf_start,
  output logic [W-1:0]           mf_x1,
  output logic [W-1:0]           mf_x2,
  output logic [W-1:0]           mf_x3,
  output logic [W-1:0]           mf_x4,
  output logic [W-1:0]           mf_eps,
  input  logic                   mf_done,
  input  logic [W-1:0]           mf_result
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   win_id;
  logic [IW-1:0]   grant_id;
  logic            grant_found;
  logic [IW:0]     sum;
  logic [TW-1:0]   timer;
  logic            timeout_hit;
  logic [5*W-1:0]  slots [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_slot
    assign slots[i] = req_data[i*5*W +: 5*W];
  end

  assign timeout_hit = (timer == TW'(TIMEOUT - 1));

  // Descending scan so the requester closest to rr_ptr is the last (winning) assignment.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    sum         = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(N_REQ)) sum = sum - (IW+1)'(N_REQ);
      if (req[sum[IW-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = sum[IW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mf_start  = 1'b0;
    rsp_valid = 1'b0;
    rsp_id    = '0;
    busy      = (state != IDLE);
    case (state)
      IDLE:  if (grant_found) state_nxt = START;
      START: begin
        mf_start  = 1'b1;
        state_nxt = WAIT;
      end
      WAIT:  if (mf_done || timeout_hit) state_nxt = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        rsp_id    = 3'(win_id);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are captured only on a grant, so they stay put from START until RESP.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr   <= '0;
      win_id   <= '0;
      timer    <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
      mf_x1    <= '0;
      mf_x2    <= '0;
      mf_x3    <= '0;
      mf_x4    <= '0;
      mf_eps   <= '0;
    end else begin
      case (state)
        IDLE: if (grant_found) begin
          win_id <= grant_id;
          {mf_eps, mf_x4, mf_x3, mf_x2, mf_x1} <= slots[grant_id];
        end
        START: timer <= '0;
        WAIT: begin
          if (mf_done) begin
            rsp_data <= mf_result;
            rsp_err  <= 1'b0;
          end else if (timeout_hit) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RESP: rr_ptr <= (win_id == IW'(N_REQ - 1)) ? '0 : win_id + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_maxfinder_sched.sv
// Self-checking bench for maxfinder_sched: scoreboard of expected responses plus a
// behavioural maxfinder stub with programmable done latency or hang.
module tb_maxfinder_sched;

  localparam int N  = 4;
  localparam int W  = 5;
  localparam int TO = 8;

  typedef struct packed {
    logic [2:0]   id;
    logic [W-1:0] data;
    logic         err;
  } exp_t;

  logic             clk;
  logic             rst;
  logic [N-1:0]     req;
  logic [N*5*W-1:0] req_data;
  logic             rsp_valid;
  logic [2:0]       rsp_id;
  logic [W-1:0]     rsp_data;
  logic             rsp_err;
  logic             busy;
  logic             mf_start;
  logic [W-1:0]     mf_x1, mf_x2, mf_x3, mf_x4, mf_eps;
  logic             mf_done;
  logic [W-1:0]     mf_result;

  exp_t           sb[$];
  logic [5*W-1:0] op_q[$];

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int n_rsp = 0;
  int n_start = 0;
  int start_cycle = 0;
  int last_lat = 0;
  int model_cnt = 0;
  int model_lat = 2;
  bit model_hang = 0;
  bit spurious = 0;
  logic [W-1:0]   model_val;
  logic [5*W-1:0] last_ops;

  maxfinder_sched #(.N_REQ(N), .W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .mf_start(mf_start),
    .mf_x1(mf_x1), .mf_x2(mf_x2), .mf_x3(mf_x3), .mf_x4(mf_x4), .mf_eps(mf_eps),
    .mf_done(mf_done), .mf_result(mf_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] mx(input logic [5*W-1:0] o);
    logic [W-1:0] m;
    m = o[W-1:0];
    for (int i = 1; i < 4; i++) if (o[i*W +: W] > m) m = o[i*W +: W];
    return m;
  endfunction

  function automatic logic [5*W-1:0] cur_ops();
    return {mf_eps, mf_x4, mf_x3, mf_x2, mf_x1};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int id, input logic [5*W-1:0] ops, input bit err);
    exp_t e;
    req_data[id*5*W +: 5*W] = ops;
    req[id] = 1'b1;
    op_q.push_back(ops);
    e.id   = 3'(id);
    e.data = err ? '0 : mx(ops);
    e.err  = err;
    sb.push_back(e);
  endtask

  // One clock: sample at negedge, then requester drops and stub updates just after posedge.
  task automatic tick();
    bit drop;
    int drop_id;
    exp_t e;
    drop = 0;
    drop_id = 0;
    @(negedge clk);
    if (mf_start) begin
      n_start++;
      start_cycle = cycle;
      last_ops = cur_ops();
      if (op_q.size() == 0) checkOutput("unexpected_start", 1, 0);
      else checkOutput("mf_ops", 32'(cur_ops()), 32'(op_q.pop_front()));
      model_val = mx(cur_ops());
      model_cnt = model_hang ? -1 : model_lat;
    end
    if (rsp_valid) begin
      n_rsp++;
      last_lat = cycle - start_cycle;
      checkOutput("ops_hold", 32'(cur_ops()), 32'(last_ops));
      if (sb.size() == 0) checkOutput("unexpected_rsp", 1, 0);
      else begin
        e = sb.pop_front();
        checkOutput("rsp_id", 32'(rsp_id), 32'(e.id));
        checkOutput("rsp_data", 32'(rsp_data), 32'(e.data));
        checkOutput("rsp_err", 32'(rsp_err), 32'(e.err));
      end
      drop = 1;
      drop_id = int'(rsp_id);
    end
    @(posedge clk);
    #1;
    cycle++;
    if (drop && drop_id < N) req[drop_id] = 1'b0;
    mf_done = spurious;
    if (model_cnt > 0) begin
      model_cnt--;
      if (model_cnt == 0) begin
        mf_done   = 1'b1;
        mf_result = model_val;
      end
    end
  endtask

  task automatic runUntil(input int target, input int budget);
    int t;
    t = 0;
    while (n_rsp < target && t < budget) begin
      tick();
      t++;
    end
    if (n_rsp < target) checkOutput("rsp_wait_budget", 32'(n_rsp), 32'(target));
  endtask

  task automatic doReset();
    rst = 1'b0;
    req = '0;
    mf_done = 1'b0;
    model_cnt = 0;
    model_hang = 0;
    sb.delete();
    op_q.delete();
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    logic [5*W-1:0] ops_a, ops_b, ops_c;
    int s0, r0;
    rst = 1'b0;
    req = '0;
    req_data = '0;
    mf_done = 1'b0;
    mf_result = '0;
    model_val = '0;
    last_ops = '0;

    doReset();
    checkOutput("reset_outs", 32'({rsp_valid, rsp_id, rsp_data, rsp_err, busy, mf_start}), 0);
    checkOutput("reset_ops", 32'(cur_ops()), 0);

    // Single request from requester 0
    s0 = n_start;
    model_lat = 3;
    applyStimulus(0, {5'b11110, 5'b00010, 5'b00100, 5'b01000, 5'b00110}, 0);
    runUntil(n_rsp + 1, 50);
    checkOutput("t1_latency", 32'(last_lat), 4);
    checkOutput("t1_starts", 32'(n_start - s0), 1);

    // Full contention, grants expected 0,1,2,3
    doReset();
    s0 = n_start;
    model_lat = 2;
    for (int i = 0; i < N; i++) applyStimulus(i, 25'($urandom), 0);
    runUntil(n_rsp + 4, 200);
    checkOutput("t2_starts", 32'(n_start - s0), 4);
    checkOutput("t2_req_cleared", 32'(req), 0);

    // Fairness: after 2 is served, 0 wins over 2
    doReset();
    applyStimulus(2, 25'($urandom), 0);
    runUntil(n_rsp + 1, 50);
    applyStimulus(0, 25'($urandom), 0);
    applyStimulus(2, 25'($urandom), 0);
    runUntil(n_rsp + 2, 100);

    // Timeout with done held low, then done on the final WAIT cycle
    doReset();
    model_hang = 1;
    applyStimulus(3, 25'($urandom), 1);
    runUntil(n_rsp + 1, 100);
    checkOutput("t4_timeout_lat", 32'(last_lat), TO + 1);
    tick();
    checkOutput("t4_err_hold", 32'({rsp_err, rsp_data}), 32'({1'b1, 5'b00000}));
    model_hang = 0;
    model_lat = TO;
    ops_a = 25'($urandom);
    applyStimulus(1, ops_a, 0);
    runUntil(n_rsp + 1, 100);
    checkOutput("t4_edge_lat", 32'(last_lat), TO + 1);
    tick();
    checkOutput("t4_data_hold", 32'({rsp_err, rsp_data}), 32'({1'b0, mx(ops_a)}));

    // Reset while in WAIT aborts silently
    model_hang = 1;
    applyStimulus(2, 25'($urandom), 0);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("t5_busy_wait", 32'(busy), 1);
    rst = 1'b0;
    req = '0;
    tick();
    rst = 1'b1;
    model_hang = 0;
    model_cnt = 0;
    sb.delete();
    op_q.delete();
    checkOutput("t5_reset_outs", 32'({rsp_valid, rsp_id, rsp_data, rsp_err, busy, mf_start}), 0);
    checkOutput("t5_reset_ops", 32'(cur_ops()), 0);
    r0 = n_rsp;
    for (int i = 0; i < 10; i++) tick();
    checkOutput("t5_no_rsp", 32'(n_rsp - r0), 0);
    model_lat = 2;
    ops_b = 25'($urandom);
    applyStimulus(1, ops_b, 0);
    runUntil(n_rsp + 1, 50);

    // Spurious done in IDLE, then req_data changing during WAIT
    r0 = n_rsp;
    s0 = n_start;
    spurious = 1;
    for (int i = 0; i < 6; i++) tick();
    spurious = 0;
    tick();
    checkOutput("t6_spurious_rsp", 32'(n_rsp - r0), 0);
    checkOutput("t6_spurious_start", 32'(n_start - s0), 0);
    checkOutput("t6_idle_busy", 32'(busy), 0);
    checkOutput("t6_ops_kept", 32'(cur_ops()), 32'(ops_b));
    model_lat = 4;
    ops_c = 25'($urandom);
    applyStimulus(0, ops_c, 0);
    for (int i = 0; i < 3; i++) tick();
    req_data[0 +: 5*W] = ~ops_c;
    runUntil(n_rsp + 1, 50);
    tick();
    checkOutput("t6_ops_after", 32'(cur_ops()), 32'(ops_c));
    checkOutput("t6_sb_empty", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
